uart_tx_queue: RTL and testbench

Byte queue that sits directly upstream of the `uart` transmitter's `tx_en`/`tx_data`/`tx_rdy` port. Producers such as banner text, echo logic or status reporters push bytes at any rate up to one per clock. The block buffers them in a FIFO and drains them to the UART with the four-phase `tx_rdy`/`tx_en` handshake, one byte per UART frame. It replaces ad-hoc per-producer handshake state machines in the top level.

---
 rtl/uart_tx_queue.sv | 116 +++++++++++
 tb/tb_uart_tx_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the uart transmitter through the four-phase tx_rdy/tx_en handshake.
// Producers push at up to one byte per clock; the drain FSM pops one byte per UART frame.
module uart_tx_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    input  logic          ovf_clr,
    input  logic          tx_rdy,
    output logic          tx_en,
    output logic [7:0]    tx_data,
    output logic          busy
);

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic [7:0]    r_tx_data;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // A pop on the same edge never frees room for a push against a full queue.
    assign w_push  = wr_en && !w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && tx_rdy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!tx_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_tx_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_tx_data <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (ovf_clr) begin
                r_ovf <= 1'b0;
            end else if (wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = r_count;
    assign ovf     = r_ovf;
    assign tx_en   = (r_state == S_ACK);
    assign tx_data = r_tx_data;
    assign busy    = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: expected bytes queued at push time and
// compared when the UART side observes a tx_en pulse.
module tb_uart_tx_queue;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        ovf;
    logic        ovf_clr;
    logic        tx_rdy;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        busy;

    logic        uart_auto;
    logic        man_rdy;
    logic        model_rdy;
    int          n_tests;
    int          n_fail;
    int          pulses;
    logic [7:0]  sb[$];

    assign tx_rdy = uart_auto ? model_rdy : man_rdy;

    uart_tx_queue #(.DEPTH(16), .AW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .tx_rdy  (tx_rdy),
        .tx_en   (tx_en),
        .tx_data (tx_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit expect_accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_accept) sb.push_back(b);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (sb.size() == 0 && !busy && tx_rdy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_drain_done"}, done, 1);
        chk({tag, "_sb_left"}, sb.size(), 0);
    endtask

    // UART model: latches the byte on tx_en, drops tx_rdy for a random frame time.
    initial begin
        logic [7:0] exp;
        int frame;
        model_rdy = 1'b1;
        pulses    = 0;
        forever begin
            @(posedge clk);
            #2;
            if (uart_auto && tx_en) begin
                pulses++;
                if (sb.size() == 0) begin
                    chk("extra_tx_en", 1, 0);
                end else begin
                    exp = sb.pop_front();
                    chk("uart_tx_data", tx_data, exp);
                end
                model_rdy = 1'b0;
                frame = $urandom_range(1, 40);
                repeat (frame) @(posedge clk);
                #2;
                model_rdy = 1'b1;
            end
        end
    end

    initial begin
        string hello;
        int p0;
        int highs;
        logic [7:0] e;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        ovf_clr   = 1'b0;
        man_rdy   = 1'b1;
        uart_auto = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);

        // Single byte, manual handshake
        push(8'h48, 1'b0);
        chk("t1_count_after_push", count, 1);
        chk("t1_tx_en_not_yet", tx_en, 0);
        tick();
        chk("t1_tx_en", tx_en, 1);
        chk("t1_tx_data", tx_data, 8'h48);
        chk("t1_count_popped", count, 0);
        chk("t1_busy_ack", busy, 1);
        repeat (3) tick();
        chk("t1_tx_en_held", tx_en, 1);
        man_rdy = 1'b0;
        tick();
        chk("t1_tx_en_fall", tx_en, 0);
        chk("t1_count_end", count, 0);
        chk("t1_busy_end", busy, 0);
        man_rdy = 1'b1;
        repeat (3) tick();
        chk("t1_no_repeat", tx_en, 0);
        chk("t1_data_held", tx_data, 8'h48);

        // Hello string against random-frame UART
        uart_auto = 1'b1;
        p0 = pulses;
        hello = "Hello, world!\r\n";
        for (int i = 0; i < hello.len(); i++) push(hello[i], 1'b1);
        wait_drain("t2");
        chk("t2_pulses", pulses - p0, 15);

        // Overflow with UART stalled
        uart_auto = 1'b0;
        man_rdy   = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push(8'(i), i < 16);
            if (i == 14) chk("t3_not_full_15", full, 0);
            if (i == 15) begin
                chk("t3_full_16", full, 1);
                chk("t3_count_16", count, 16);
                chk("t3_ovf_before_drop", ovf, 0);
            end
        end
        chk("t3_ovf_set", ovf, 1);
        chk("t3_count_after_drop", count, 16);
        tick();
        chk("t3_ovf_sticky", ovf, 1);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        ovf_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        chk("t3_ovf_clr_priority", ovf, 0);
        chk("t3_count_still_full", count, 16);
        p0 = pulses;
        uart_auto = 1'b1;
        wait_drain("t3");
        chk("t3_pulses", pulses - p0, 16);

        // Simultaneous push/pop across pointer wrap
        for (int i = 0; i < 12; i++) push(8'h20 + 8'(i), 1'b1);
        wait_drain("t4a");
        uart_auto = 1'b0;
        man_rdy   = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 1'b1);
        chk("t4_count5", count, 5);
        for (int k = 0; k < 6; k++) begin
            man_rdy = 1'b1;
            wr_en   = 1'b1;
            wr_data = 8'h50 + 8'(k);
            sb.push_back(wr_data);
            tick();
            wr_en = 1'b0;
            chk("t4_count_stays", count, 5);
            chk("t4_tx_en", tx_en, 1);
            if (sb.size() == 0) begin
                chk("t4_sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("t4_tx_data", tx_data, e);
            end
            man_rdy = 1'b0;
            tick();
            chk("t4_tx_en_low", tx_en, 0);
        end
        uart_auto = 1'b1;
        wait_drain("t4b");

        // Asynchronous reset mid-handshake
        uart_auto = 1'b0;
        man_rdy   = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i), 1'b0);
        man_rdy = 1'b1;
        tick();
        chk("t5_tx_en_ack", tx_en, 1);
        chk("t5_count3", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_tx_en", tx_en, 0);
        chk("t5_async_count", count, 0);
        chk("t5_async_empty", empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_en) highs++;
        end
        chk("t5_no_tx_after", highs, 0);
        chk("t5_count_after", count, 0);
        chk("t5_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
